// File: rtl/axi_rb_engine_pkg.sv
// Shared types and AXI constants for the read-burst engine.
package axi_rb_engine_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData,
    StDone
  } rb_state_e;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam int unsigned AXI_4K_BYTES   = 4096;

  // AXI size code for a beat of data_width bits.
  function automatic logic [2:0] axi_size(input int unsigned data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/axi_burst_splitter.sv
// Combinational burst-length calculator: min(remaining beats, MAX_BURST, beats left in 4 KB page).
module axi_burst_splitter
  import axi_rb_engine_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic [11:0]          addr,
  input  logic [LEN_WIDTH-1:0] remain,
  output logic [8:0]           blen
);

  localparam int unsigned Lsb  = $clog2(DATA_WIDTH / 8);
  localparam int unsigned CmpW = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;

  logic [12:0]     page_beats;
  logic [12:0]     cap;
  logic [CmpW-1:0] remain_ext;
  logic [CmpW-1:0] cap_ext;

  always_comb begin
    // addr is beat-aligned, so the byte room divides exactly into beats
    page_beats = (13'(AXI_4K_BYTES) - {1'b0, addr}) >> Lsb;
    cap        = (page_beats < 13'(MAX_BURST)) ? page_beats : 13'(MAX_BURST);
    remain_ext = CmpW'(remain);
    cap_ext    = CmpW'(cap);
    blen       = (remain_ext < cap_ext) ? 9'(remain_ext) : 9'(cap_ext);
  end

endmodule

// File: rtl/axi_rb_engine.sv
// AXI4 read-burst engine: splits a {address, beats} command into INCR bursts and streams
// the returned beats into a FIFO, signalling completion and sticky error status with done.
module axi_rb_engine
  import axi_rb_engine_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]  start_beats,
  output logic [ADDR_WIDTH-1:0] s_axi_araddr,
  output logic [7:0]            s_axi_arlen,
  output logic [2:0]            s_axi_arsize,
  output logic [1:0]            s_axi_arburst,
  output logic                  s_axi_arvalid,
  input  logic                  s_axi_arready,
  input  logic [DATA_WIDTH-1:0] s_axi_rdata,
  input  logic [1:0]            s_axi_rresp,
  input  logic                  s_axi_rlast,
  input  logic                  s_axi_rvalid,
  output logic                  s_axi_rready,
  output logic [DATA_WIDTH-1:0] fifo_in_data,
  output logic                  fifo_write_valid,
  input  logic                  fifo_write_ready,
  output logic                  done,
  output logic                  err,
  output logic                  busy
);

  localparam int unsigned           Lsb       = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] AlignMask = ~ADDR_WIDTH'(DATA_WIDTH / 8 - 1);
  localparam logic [2:0]            ArSize    = axi_size(DATA_WIDTH);

  rb_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  remain_q, remain_d;
  logic [8:0]            beat_cnt_q, beat_cnt_d;
  logic                  err_q, err_d;
  logic [8:0]            blen_q;
  logic [8:0]            blen;
  logic [ADDR_WIDTH-1:0] burst_bytes;
  logic                  beat_fire;

  // Sized from the next-state address/remain so blen is ready as ADDR is entered
  axi_burst_splitter #(
    .DATA_WIDTH (DATA_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH),
    .MAX_BURST  (MAX_BURST)
  ) u_splitter (
    .addr   (addr_d[11:0]),
    .remain (remain_d),
    .blen   (blen)
  );

  assign burst_bytes = ADDR_WIDTH'(blen_q) << Lsb;
  assign beat_fire   = s_axi_rvalid && fifo_write_ready;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    unique case (state_q)
      StIdle: begin
        if (start_valid) begin
          addr_d   = start_addr & AlignMask;
          remain_d = start_beats;
          err_d    = 1'b0;
          state_d  = (start_beats == '0) ? StDone : StAddr;
        end
      end
      StAddr: begin
        if (s_axi_arready) begin
          beat_cnt_d = blen_q;
          state_d    = StData;
        end
      end
      StData: begin
        if (beat_fire) begin
          beat_cnt_d = beat_cnt_q - 9'd1;
          remain_d   = remain_q - LEN_WIDTH'(1);
          if (s_axi_rresp != AXI_RESP_OKAY) err_d = 1'b1;
          // rlast must coincide exactly with the counter's final beat
          if (s_axi_rlast != (beat_cnt_q == 9'd1)) err_d = 1'b1;
          if (beat_cnt_q == 9'd1) begin
            addr_d  = addr_q + burst_bytes;
            state_d = (remain_q == LEN_WIDTH'(1)) ? StDone : StAddr;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      remain_q   <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      blen_q     <= 9'd1;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
      if (state_d == StAddr && state_q != StAddr) blen_q <= blen;
    end
  end

  always_comb begin
    start_ready      = (state_q == StIdle);
    busy             = (state_q != StIdle);
    s_axi_arvalid    = (state_q == StAddr);
    s_axi_araddr     = addr_q;
    s_axi_arlen      = 8'(blen_q - 9'd1);
    s_axi_arsize     = ArSize;
    s_axi_arburst    = AXI_BURST_INCR;
    s_axi_rready     = (state_q == StData) && fifo_write_ready;
    fifo_write_valid = (state_q == StData) && s_axi_rvalid;
    fifo_in_data     = s_axi_rdata;
    done             = (state_q == StDone);
    err              = (state_q == StDone) && err_q;
  end

endmodule

// File: tb/tb_axi_rb_engine.sv
// Self-checking bench for axi_rb_engine: randomised AXI slave and FIFO sink, checked against
// a burst/beat reference model computed from addresses and beat counts.
module tb_axi_rb_engine;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int LW = 16;
  localparam int MB = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_valid = 1'b0;
  logic          start_ready;
  logic [AW-1:0] start_addr = '0;
  logic [LW-1:0] start_beats = '0;
  logic [AW-1:0] s_axi_araddr;
  logic [7:0]    s_axi_arlen;
  logic [2:0]    s_axi_arsize;
  logic [1:0]    s_axi_arburst;
  logic          s_axi_arvalid;
  logic          s_axi_arready = 1'b0;
  logic [DW-1:0] s_axi_rdata = '0;
  logic [1:0]    s_axi_rresp = '0;
  logic          s_axi_rlast = 1'b0;
  logic          s_axi_rvalid = 1'b0;
  logic          s_axi_rready;
  logic [DW-1:0] fifo_in_data;
  logic          fifo_write_valid;
  logic          fifo_write_ready = 1'b0;
  logic          done;
  logic          err;
  logic          busy;

  axi_rb_engine #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW),
    .MAX_BURST  (MB)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start_valid      (start_valid),
    .start_ready      (start_ready),
    .start_addr       (start_addr),
    .start_beats      (start_beats),
    .s_axi_araddr     (s_axi_araddr),
    .s_axi_arlen      (s_axi_arlen),
    .s_axi_arsize     (s_axi_arsize),
    .s_axi_arburst    (s_axi_arburst),
    .s_axi_arvalid    (s_axi_arvalid),
    .s_axi_arready    (s_axi_arready),
    .s_axi_rdata      (s_axi_rdata),
    .s_axi_rresp      (s_axi_rresp),
    .s_axi_rlast      (s_axi_rlast),
    .s_axi_rvalid     (s_axi_rvalid),
    .s_axi_rready     (s_axi_rready),
    .fifo_in_data     (fifo_in_data),
    .fifo_write_valid (fifo_write_valid),
    .fifo_write_ready (fifo_write_ready),
    .done             (done),
    .err              (err),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Observed traffic
  logic [15:0] obs_addr[$];
  logic [7:0]  obs_len[$];
  logic [4:0]  obs_meta[$];
  logic [31:0] obs_data[$];
  int          done_cnt = 0;
  logic        last_err = 1'b0;
  logic        ar_fire = 1'b0;
  logic        r_fire = 1'b0;
  logic [15:0] ar_addr_s = '0;
  logic [7:0]  ar_len_s = '0;

  // Expected traffic
  logic [15:0] exp_addr[$];
  logic [7:0]  exp_len[$];
  logic [31:0] exp_data[$];

  // Slave / sink controls
  bit          sl_busy = 1'b0;
  logic [15:0] sl_addr = '0;
  int          sl_len = 0;
  int          sl_idx = 0;
  int          cmd_beat = 0;
  int          cmd_total = 0;
  int          err_mode = 0;
  logic [15:0] cmd_tag = '0;
  bit          sl_rand = 1'b1;
  bit          fifo_rand = 1'b1;
  int          hold_after = -1;
  int          hold_left = 0;

  // Monitor: samples mid-cycle, handshakes complete at the following rising edge
  initial begin
    forever begin
      @(negedge clk);
      ar_fire = 1'b0;
      r_fire  = 1'b0;
      if (!rst) begin
        if (s_axi_arvalid && s_axi_arready) begin
          ar_fire   = 1'b1;
          ar_addr_s = s_axi_araddr;
          ar_len_s  = s_axi_arlen;
          obs_addr.push_back(s_axi_araddr);
          obs_len.push_back(s_axi_arlen);
          obs_meta.push_back({s_axi_arsize, s_axi_arburst});
        end
        if (s_axi_rvalid && s_axi_rready) r_fire = 1'b1;
        if (fifo_write_valid && fifo_write_ready) obs_data.push_back(fifo_in_data);
        if (done) begin
          done_cnt++;
          last_err = err;
        end
      end
    end
  end

  // AXI read slave: one burst at a time, optional random rvalid gaps and error injection
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        sl_busy       = 1'b0;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
      end else begin
        if (!sl_busy) begin
          if (ar_fire) begin
            sl_busy       = 1'b1;
            sl_addr       = ar_addr_s;
            sl_len        = int'(ar_len_s) + 1;
            sl_idx        = 0;
            s_axi_arready = 1'b0;
          end else begin
            s_axi_arready = sl_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
          end
        end else if (r_fire) begin
          sl_idx++;
          cmd_beat++;
          s_axi_rvalid = 1'b0;
          if (sl_idx == sl_len) sl_busy = 1'b0;
        end
        if (sl_busy && !s_axi_rvalid && (!sl_rand || $urandom_range(0, 3) != 0)) begin
          s_axi_rvalid = 1'b1;
          s_axi_rdata  = {cmd_tag, 16'(int'(sl_addr) + 4 * sl_idx)};
          s_axi_rresp  = (err_mode == 1 && cmd_beat == 1) ? 2'b10 : 2'b00;
          s_axi_rlast  = (sl_idx == sl_len - 1);
          if (err_mode == 2 && cmd_beat == cmd_total - 1) s_axi_rlast = 1'b0;
          if (err_mode == 3 && cmd_beat == 0) s_axi_rlast = 1'b1;
        end
      end
    end
  end

  // FIFO sink readiness, with an optional fixed 3-cycle stall after hold_after writes
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (hold_left > 0) begin
        fifo_write_ready = 1'b0;
        hold_left--;
      end else if (hold_after >= 0 && obs_data.size() == hold_after) begin
        fifo_write_ready = 1'b0;
        hold_left        = 2;
        hold_after       = -1;
      end else begin
        fifo_write_ready = fifo_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // Reference: bursts are min(remaining, 16, words to next 4 KB page); data tags each beat address
  task automatic model_cmd(input logic [15:0] a, input int beats);
    int          remain;
    int          room;
    int          b;
    logic [15:0] cur;
    exp_addr.delete();
    exp_len.delete();
    exp_data.delete();
    cur    = a & 16'hFFFC;
    remain = beats;
    for (int k = 0; k < beats; k++) exp_data.push_back({cmd_tag, 16'(int'(cur) + 4 * k)});
    while (remain > 0) begin
      room = (4096 - (int'(cur) % 4096)) / 4;
      b    = remain;
      if (b > MB) b = MB;
      if (b > room) b = room;
      exp_addr.push_back(cur);
      exp_len.push_back(8'(b - 1));
      cur    = 16'(int'(cur) + 4 * b);
      remain = remain - b;
    end
  endtask

  task automatic run_cmd(input string name, input logic [15:0] a, input int beats,
                         input logic exp_err, output int zero_cyc, output int viol);
    int cyc;
    int n;
    cmd_tag   = 16'($urandom);
    cmd_beat  = 0;
    cmd_total = beats;
    model_cmd(a, beats);
    obs_addr.delete();
    obs_len.delete();
    obs_meta.delete();
    obs_data.delete();
    done_cnt = 0;
    zero_cyc = 0;
    viol     = 0;
    @(posedge clk);
    #1;
    start_valid = 1'b1;
    start_addr  = a;
    start_beats = LW'(beats);
    @(negedge clk);
    #1;
    chk_cnt++;
    if (start_ready !== 1'b1) $display("FAIL %s start_ready: got %b want 1", name, start_ready);
    else pass_cnt++;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    start_addr  = 16'($urandom);
    start_beats = LW'($urandom);
    @(negedge clk);
    #1;
    chk_cnt++;
    if (beats == 0) begin
      if ({s_axi_arvalid, done, err} !== 3'b010)
        $display("FAIL %s zero_done_t1: got arvalid/done/err %b want 010", name,
                 {s_axi_arvalid, done, err});
      else pass_cnt++;
    end else begin
      if (s_axi_arvalid !== 1'b1) $display("FAIL %s arvalid_t1: got %b want 1", name, s_axi_arvalid);
      else pass_cnt++;
    end
    cyc = 0;
    while (done_cnt == 0 && cyc < 3000) begin
      if (fifo_write_ready === 1'b0 && busy === 1'b1) begin
        zero_cyc++;
        if (s_axi_rready !== 1'b0) viol++;
      end
      @(negedge clk);
      #1;
      cyc++;
    end
    if (done_cnt == 0) begin
      chk_cnt++;
      $display("FAIL %s timeout: got no done after %0d cycles want done", name, cyc);
      rst = 1'b1;
      @(negedge clk);
      #2 rst = 1'b0;
    end
    repeat (3) begin
      @(negedge clk);
      #1;
    end
    chk_cnt++;
    if (obs_addr.size() != exp_addr.size())
      $display("FAIL %s ar_count: got %0d want %0d", name, obs_addr.size(), exp_addr.size());
    else pass_cnt++;
    n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      chk_cnt++;
      if ({obs_addr[i], obs_len[i], obs_meta[i]} !== {exp_addr[i], exp_len[i], 3'd2, 2'd1})
        $display("FAIL %s ar[%0d]: got addr %h len %0d size/burst %b want addr %h len %0d 01001",
                 name, i, obs_addr[i], obs_len[i], obs_meta[i], exp_addr[i], exp_len[i]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (obs_data.size() != exp_data.size())
      $display("FAIL %s beat_count: got %0d want %0d", name, obs_data.size(), exp_data.size());
    else pass_cnt++;
    n = (obs_data.size() < exp_data.size()) ? obs_data.size() : exp_data.size();
    for (int i = 0; i < n; i++) begin
      chk_cnt++;
      if (obs_data[i] !== exp_data[i])
        $display("FAIL %s data[%0d]: got %h want %h", name, i, obs_data[i], exp_data[i]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (done_cnt != 1) $display("FAIL %s done_pulses: got %0d want 1", name, done_cnt);
    else pass_cnt++;
    chk_cnt++;
    if (last_err !== exp_err) $display("FAIL %s err: got %b want %b", name, last_err, exp_err);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    chk_cnt++;
    if ({start_ready, busy} !== 2'b10)
      $display("FAIL reset_ready_busy: got %b want 10", {start_ready, busy});
    else pass_cnt++;
    chk_cnt++;
    if ({s_axi_arvalid, s_axi_rready, fifo_write_valid, done, err} !== 5'b0)
      $display("FAIL reset_strobes: got %b want 00000",
               {s_axi_arvalid, s_axi_rready, fifo_write_valid, done, err});
    else pass_cnt++;
    chk_cnt++;
    if ({s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst} !== {16'h0, 8'h0, 3'd2, 2'd1})
      $display("FAIL reset_ar_fields: got %h/%h/%0d/%0d want 0000/00/2/1", s_axi_araddr,
               s_axi_arlen, s_axi_arsize, s_axi_arburst);
    else pass_cnt++;
    s_axi_rdata = 32'h1234ABCD;
    #1;
    chk_cnt++;
    if (fifo_in_data !== 32'h1234ABCD)
      $display("FAIL reset_data_passthru: got %h want 1234abcd", fifo_in_data);
    else pass_cnt++;
    start_valid = 1'b1;
    start_beats = 16'd5;
    @(posedge clk);
    #1;
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL start_in_reset: got busy %b want 0", busy);
    else pass_cnt++;
    start_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic test_single();
    int z, v;
    run_cmd("single", 16'h0100, 4, 1'b0, z, v);
  endtask

  task automatic test_multi();
    int z, v;
    run_cmd("multi", 16'h0000, 40, 1'b0, z, v);
  endtask

  task automatic test_4k();
    int z, v;
    run_cmd("cross4k", 16'h0FF8, 6, 1'b0, z, v);
    run_cmd("unaligned", 16'h0FFB, 3, 1'b0, z, v);
  endtask

  task automatic test_backpressure();
    int z, v;
    sl_rand    = 1'b0;
    fifo_rand  = 1'b0;
    hold_after = 3;
    run_cmd("backpressure", 16'h0300, 8, 1'b0, z, v);
    chk_cnt++;
    if (z != 3) $display("FAIL bp_stall_cycles: got %0d want 3", z);
    else pass_cnt++;
    chk_cnt++;
    if (v != 0) $display("FAIL bp_rready_while_full: got %0d cycles want 0", v);
    else pass_cnt++;
    hold_after = -1;
    sl_rand    = 1'b1;
    fifo_rand  = 1'b1;
  endtask

  task automatic test_zero();
    int z, v;
    run_cmd("zero_beats", 16'($urandom), 0, 1'b0, z, v);
  endtask

  task automatic test_errors();
    int z, v;
    err_mode = 1;
    run_cmd("err_rresp", 16'h0500, 8, 1'b1, z, v);
    err_mode = 2;
    run_cmd("err_no_rlast", 16'h0600, 5, 1'b1, z, v);
    err_mode = 3;
    run_cmd("err_early_rlast", 16'h0700, 4, 1'b1, z, v);
    err_mode = 0;
    run_cmd("err_cleared", 16'h0800, 4, 1'b0, z, v);
  endtask

  task automatic test_reset_mid();
    int cyc;
    int z, v;
    sl_rand   = 1'b0;
    fifo_rand = 1'b0;
    err_mode  = 0;
    cmd_tag   = 16'($urandom);
    cmd_beat  = 0;
    cmd_total = 8;
    obs_data.delete();
    done_cnt = 0;
    @(posedge clk);
    #1;
    start_valid = 1'b1;
    start_addr  = 16'h0400;
    start_beats = 16'd8;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    cyc = 0;
    while (obs_data.size() < 3 && cyc < 200) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    @(posedge clk);
    #3;
    chk_cnt++;
    if ({s_axi_rready, fifo_write_valid, busy} !== 3'b111)
      $display("FAIL rstmid_pre: got rready/fwv/busy %b want 111",
               {s_axi_rready, fifo_write_valid, busy});
    else pass_cnt++;
    rst = 1'b1;
    #1;
    chk_cnt++;
    if ({s_axi_rready, fifo_write_valid, busy, start_ready} !== 4'b0001)
      $display("FAIL rstmid_async: got rready/fwv/busy/start_ready %b want 0001",
               {s_axi_rready, fifo_write_valid, busy, start_ready});
    else pass_cnt++;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    sl_rand   = 1'b1;
    fifo_rand = 1'b1;
    run_cmd("after_reset", 16'h0FF0, 12, 1'b0, z, v);
  endtask

  task automatic test_random();
    int          z, v;
    int          b;
    logic [15:0] a;
    for (int n = 0; n < 16; n++) begin
      a = 16'($urandom);
      if (n % 3 == 1) a = 16'($urandom_range(1, 16) * 4096 - $urandom_range(0, 80));
      b = $urandom_range(0, 60);
      if (n == 5) b = 0;
      run_cmd("random", a, b, 1'b0, z, v);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_4k();
    test_backpressure();
    test_zero();
    test_errors();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
